// File: rtl/qpsk_symbol_packer.sv
// QPSK 2-bit symbol to byte packer with a show-ahead byte FIFO, flush and sticky overflow.
// Define QPSK_PACK_LSB_FIRST_EN to place the first symbol of a byte in data_o[1:0].
module qpsk_symbol_packer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        data_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic              clear_ovf_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ADDR_W:0]   fifo_level_o,
   output logic              overflow_o
);

   localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(FIFO_DEPTH);

   logic [1:0]        r_sym_cnt;
   logic [7:0]        r_shift;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_level;
   logic [7:0]        r_data_o;
   logic              r_ovf;

   logic [2:0]        w_cnt_after;
   logic [7:0]        w_shift_next;
   logic [2:0]        w_pad_syms;
   logic [3:0]        w_shamt;
   logic [7:0]        w_byte;
   logic              w_complete;
   logic              w_flush_push;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_wr_en;
   logic              w_ovf_set;
   logic [ADDR_W-1:0] w_rd_ptr_inc;
   logic [7:0]        w_data_nxt;

   // Symbol count including any symbol arriving this cycle (4 means a full byte).
   assign w_cnt_after = {1'b0, r_sym_cnt} + {2'b00, valid_i};
   assign w_complete  = (w_cnt_after == 3'd4);
   assign w_flush_push = flush_i && (w_cnt_after != 3'd0) && !w_complete;
   assign w_push      = w_complete || w_flush_push;

   // Unfilled symbol slots become 2'b00 by shifting the partial byte into place.
   assign w_pad_syms  = 3'd4 - w_cnt_after;
   assign w_shamt     = {w_pad_syms, 1'b0};

`ifdef QPSK_PACK_LSB_FIRST_EN
   assign w_shift_next = valid_i ? {data_i, r_shift[7:2]} : r_shift;
   assign w_byte       = w_shift_next >> w_shamt;
`else
   assign w_shift_next = valid_i ? {r_shift[5:0], data_i} : r_shift;
   assign w_byte       = w_shift_next << w_shamt;
`endif

   assign w_full       = (r_level == LP_FULL);
   assign w_pop        = valid_o && ready_i;
   assign w_wr_en      = w_push && (!w_full || w_pop);
   assign w_ovf_set    = w_push && w_full && !w_pop;
   assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

   // Next head byte: a write into an empty (or emptying) FIFO shows through directly.
   always_comb begin
      w_data_nxt = r_data_o;
      if (w_wr_en && ((r_level == '0) || (w_pop && (r_level == (ADDR_W+1)'(1)))))
         w_data_nxt = w_byte;
      else if (w_pop && (r_level > (ADDR_W+1)'(1)))
         w_data_nxt = r_mem[w_rd_ptr_inc];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sym_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_shift <= w_shift_next;
         if (w_push)
            r_sym_cnt <= '0;
         else
            r_sym_cnt <= w_cnt_after[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr] <= w_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_data_o <= 8'h00;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_en)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= w_rd_ptr_inc;
         case ({w_wr_en, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         r_data_o <= w_data_nxt;
         // Set takes priority over a same-cycle clear.
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (clear_ovf_i)
            r_ovf <= 1'b0;
      end
   end

   assign data_o       = r_data_o;
   assign valid_o      = (r_level != '0);
   assign fifo_level_o = r_level;
   assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Self-checking bench for qpsk_symbol_packer: queue-based reference model, directed cases and random traffic.
module tb_qpsk_symbol_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] data_i = 2'b00;
   logic       valid_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       clear_ovf_i = 1'b0;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic [3:0] fifo_level_o;
   logic       overflow_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [7:0] mq[$];
   logic [1:0] sq[$];
   bit         m_ovf = 1'b0;

   qpsk_symbol_packer #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .flush_i(flush_i),
      .clear_ovf_i(clear_ovf_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .fifo_level_o(fifo_level_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Byte value from a list of symbols, missing ones taken as 2'b00.
   function automatic logic [7:0] pack(logic [1:0] s[$]);
      int b = 0;
      for (int i = 0; i < s.size(); i++) begin
`ifdef QPSK_PACK_LSB_FIRST_EN
         b += int'(s[i]) << (2 * i);
`else
         b += int'(s[i]) << (6 - 2 * i);
`endif
      end
      return 8'(b);
   endfunction

   function automatic void model_step(bit v, logic [1:0] d, bit f, bit c, bit r);
      bit pop   = (mq.size() != 0) && r;
      bit push  = 1'b0;
      bit set   = 1'b0;
      logic [7:0] b = 8'h00;
      if (v) sq.push_back(d);
      if (sq.size() == 4 || (f && sq.size() > 0)) begin
         b = pack(sq);
         sq.delete();
         push = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < 8) mq.push_back(b);
         else set = 1'b1;
      end
      if (set) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
   endfunction

   function automatic void model_reset();
      mq.delete();
      sq.delete();
      m_ovf = 1'b0;
   endfunction

   task automatic cyc(bit v, logic [1:0] d, bit f, bit c, bit r);
      valid_i = v; data_i = d; flush_i = f; clear_ovf_i = c; ready_i = r;
      @(posedge clk);
      model_step(v, d, f, c, r);
      #1;
      valid_i = 1'b0; flush_i = 1'b0; clear_ovf_i = 1'b0;
   endtask

   // Symbol order so that the delivered byte equals b in either build.
   function automatic logic [1:0] sym_of(logic [7:0] b, int i);
`ifdef QPSK_PACK_LSB_FIRST_EN
      return b[2*i +: 2];
`else
      return b[6-2*i +: 2];
`endif
   endfunction

   task automatic send_byte(logic [7:0] b, bit r);
      for (int i = 0; i < 4; i++) cyc(1'b1, sym_of(b, i), 1'b0, 1'b0, r);
   endtask

   task automatic idle(int n, bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, r);
   endtask

   // Model-vs-DUT comparison on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("valid_o", int'(valid_o), int'(mq.size() != 0));
         check("fifo_level_o", int'(fifo_level_o), mq.size());
         check("overflow_o", int'(overflow_o), int'(m_ovf));
         if (mq.size() != 0) check("data_o", int'(data_o), int'(mq[0]));
      end
   end

   initial begin
      logic [7:0] exp1, exp2;
`ifdef QPSK_PACK_LSB_FIRST_EN
      exp1 = 8'hE4; exp2 = 8'h0B;
`else
      exp1 = 8'h1B; exp2 = 8'hE0;
`endif
      #12;
      check("reset data_o", int'(data_o), 0);
      check("reset valid_o", int'(valid_o), 0);
      check("reset level", int'(fifo_level_o), 0);
      check("reset overflow", int'(overflow_o), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // Four symbols 00,01,10,11 with the sink ready.
      cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
      check("t1 valid before", int'(valid_o), 0);
      cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
      check("t1 valid", int'(valid_o), 1);
      check("t1 byte", int'(data_o), int'(exp1));
      idle(1, 1'b1);
      check("t1 valid low", int'(valid_o), 0);

      // Partial byte then flush; a second flush alone does nothing.
      cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      check("t2 flush byte", int'(data_o), int'(exp2));
      check("t2 level", int'(fifo_level_o), 1);
      cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      check("t2 empty flush", int'(fifo_level_o), 1);
      idle(2, 1'b1);

      // Fill to full, overflow the ninth, drain in order.
      for (int k = 0; k < 8; k++) send_byte(8'(k), 1'b0);
      check("t3 level full", int'(fifo_level_o), 8);
      check("t3 no ovf", int'(overflow_o), 0);
      send_byte(8'hAA, 1'b0);
      check("t3 ovf", int'(overflow_o), 1);
      check("t3 level held", int'(fifo_level_o), 8);
      for (int k = 0; k < 8; k++) begin
         check("t3 drain", int'(data_o), k);
         cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      end
      check("t3 empty", int'(valid_o), 0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

      // Full FIFO: ninth byte completes on a popping edge.
      for (int k = 0; k < 8; k++) send_byte(8'(8'h10 + k), 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, sym_of(8'h5C, i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, sym_of(8'h5C, 3), 1'b0, 1'b0, 1'b1);
      check("t4 level", int'(fifo_level_o), 8);
      check("t4 no ovf", int'(overflow_o), 0);
      check("t4 head", int'(data_o), 8'h11);
      for (int k = 0; k < 7; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      check("t4 last", int'(data_o), 8'h5C);
      idle(1, 1'b1);

      // Mid-stream asynchronous reset.
      for (int k = 0; k < 3; k++) send_byte(8'(8'h30 + k), 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      #2;
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      check("t5 data_o", int'(data_o), 0);
      check("t5 valid_o", int'(valid_o), 0);
      check("t5 level", int'(fifo_level_o), 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      check("t5 ff", int'(data_o), 8'hFF);
      check("t5 one byte", int'(fifo_level_o), 1);
      idle(2, 1'b1);

      // Overflow set beats a simultaneous clear.
      for (int k = 0; k < 9; k++) send_byte(8'(k * 3), 1'b0);
      check("t6 ovf", int'(overflow_o), 1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
      check("t6 set wins", int'(overflow_o), 1);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      check("t6 cleared", int'(overflow_o), 0);
      idle(10, 1'b1);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 3) != 0), 2'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 2) == 0));
      end
      idle(12, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
